// File: rtl/zbt_frame_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_params (package)
// Purpose  : Video-path constants and writer FSM state encoding. The capture
//            packer, playback packer and ZBT frame scheduler all share them.
// Revision : 1.0 - initial release
// ============================================================================
package video_params;

  localparam int NUM_FRAMES      = 20;     // frame slots in the ring
  localparam int LINES_PER_FRAME = 24576;  // 36-bit words per frame
  localparam int ADDR_W          = 19;     // ZBT address width
  localparam int WORD_W          = 36;     // ZBT data word width
  localparam int SLOT_W          = 5;      // slot index / frame count width

  typedef enum logic [0:0] {
    WR_IDLE    = 1'b0,
    WR_CAPTURE = 1'b1
  } wr_state_e;

endpackage
`default_nettype wire

// File: rtl/zbt_frame_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : zbt_frame_scheduler_if
// Purpose  : Word request/grant streams between the pixel packers (master)
//            and the ZBT frame scheduler (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface zbt_frame_scheduler_if;
  import video_params::*;

  logic              wr_req;
  logic [WORD_W-1:0] wr_data;
  logic              wr_grant;
  logic              rd_req;
  logic              rd_grant;
  logic              rd_valid;
  logic [WORD_W-1:0] rd_data;

  modport master (
    output wr_req, wr_data, rd_req,
    input  wr_grant, rd_grant, rd_valid, rd_data
  );

  modport slave (
    input  wr_req, wr_data, rd_req,
    output wr_grant, rd_grant, rd_valid, rd_data
  );

endinterface
`default_nettype wire

// File: rtl/zbt_ring_pointer.sv
`default_nettype none
// ============================================================================
// Module   : zbt_ring_pointer
// Purpose  : Slot index, slot base address and line offset for one side of
//            the frame ring. The base is stepped by LINES_PER_FRAME on each
//            slot advance, so no multiplier is needed.
// Revision : 1.0 - initial release
// ============================================================================
module zbt_ring_pointer
  import video_params::*;
#(
  parameter int LINES_PER_FRAME = video_params::LINES_PER_FRAME,
  parameter int ADDR_W          = video_params::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_clr,     // restart the frame at line 0
  input  logic              line_inc,     // one word consumed this cycle
  input  logic              slot_adv,     // move to the next slot
  input  logic [SLOT_W-1:0] slot_last,    // highest slot before wrapping to 0
  output logic [SLOT_W-1:0] slot,
  output logic [ADDR_W-1:0] base,
  output logic [ADDR_W-1:0] line,
  output logic              line_at_end   // line is the last word of a frame
);

  localparam logic [ADDR_W-1:0] LINE_END   = ADDR_W'(LINES_PER_FRAME - 1);
  localparam logic [ADDR_W-1:0] FRAME_STEP = ADDR_W'(LINES_PER_FRAME);
  localparam logic [ADDR_W-1:0] LINE_ONE   = (LINES_PER_FRAME > 1) ? ADDR_W'(1) : '0;

  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] line_q, line_d;

  assign line_at_end = (line_q == LINE_END);

  // Next slot/base on advance; line clear wins over increment but still
  // counts a word consumed in the same cycle.
  always_comb begin
    slot_d = slot_q;
    base_d = base_q;
    line_d = line_q;
    if (slot_adv) begin
      if (slot_q >= slot_last) begin
        slot_d = '0;
        base_d = '0;
      end else begin
        slot_d = slot_q + 1'b1;
        base_d = base_q + FRAME_STEP;
      end
    end
    if (line_clr) begin
      line_d = line_inc ? LINE_ONE : '0;
    end else if (line_inc) begin
      line_d = line_at_end ? '0 : line_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q <= '0;
      base_q <= '0;
      line_q <= '0;
    end else begin
      slot_q <= slot_d;
      base_q <= base_d;
      line_q <= line_d;
    end
  end

  assign slot = slot_q;
  assign base = base_q;
  assign line = line_q;

endmodule
`default_nettype wire

// File: rtl/zbt_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : zbt_frame_scheduler
// Purpose  : Arbitrates the single ZBT port between the capture writer and
//            the playback reader, generates frame-ring addresses and issues
//            registered commands to the ZBT driver.
// Revision : 1.0 - initial release
// ============================================================================
module zbt_frame_scheduler
  import video_params::*;
#(
  parameter int NUM_FRAMES      = video_params::NUM_FRAMES,
  parameter int LINES_PER_FRAME = video_params::LINES_PER_FRAME,
  parameter int ADDR_W          = video_params::ADDR_W,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture_start,
  input  logic                  frame_start,
  input  logic                  one_hz_enable,
  zbt_frame_scheduler_if.slave  bus,
  output logic                  capturing,
  output logic [SLOT_W-1:0]     frames_stored,
  output logic                  rd_empty,
  output logic                  zbt_we,
  output logic [ADDR_W-1:0]     zbt_addr,
  output logic [WORD_W-1:0]     zbt_wdata,
  input  logic [WORD_W-1:0]     zbt_rdata
);

  localparam int                STARVE_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [SLOT_W-1:0] FRAMES_MAX = SLOT_W'(NUM_FRAMES);
  localparam logic [SLOT_W-1:0] WR_LAST    = SLOT_W'(NUM_FRAMES - 1);

  wr_state_e             state_q, state_d;
  logic [SLOT_W-1:0]     frames_stored_q, frames_stored_d;
  logic                  advance_pending_q, advance_pending_d;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  zbt_we_q, zbt_we_d;
  logic [ADDR_W-1:0]     zbt_addr_q, zbt_addr_d;
  logic [WORD_W-1:0]     zbt_wdata_q, zbt_wdata_d;
  logic [2:0]            valid_pipe_q, valid_pipe_d;
  logic [2:0]            empty_pipe_q, empty_pipe_d;

  logic                  wr_contend, wr_grant, rd_grant, rd_advance;
  logic                  wr_line_end, wr_frame_done;
  logic [SLOT_W-1:0]     wr_slot, rd_slot, rd_last;
  logic [ADDR_W-1:0]     wr_base, wr_line, rd_base, rd_line;

  // Grants are combinational: reader has priority unless the writer has
  // lost STARVE_LIMIT contended cycles in a row.
  assign capturing     = (state_q == WR_CAPTURE);
  assign rd_empty      = (frames_stored_q == '0);
  assign wr_contend    = capturing && bus.wr_req;
  assign wr_grant      = wr_contend && (!bus.rd_req || (starve_q >= STARVE_MAX));
  assign rd_grant      = bus.rd_req && !wr_grant;
  assign wr_frame_done = wr_grant && wr_line_end;
  assign rd_advance    = frame_start && (advance_pending_q || one_hz_enable);
  assign rd_last       = rd_empty ? '0 : frames_stored_q - 1'b1;

  zbt_ring_pointer #(
    .LINES_PER_FRAME (LINES_PER_FRAME),
    .ADDR_W          (ADDR_W)
  ) u_wr_ptr (
    .clk         (clk),
    .reset       (reset),
    .line_clr    (1'b0),
    .line_inc    (wr_grant),
    .slot_adv    (wr_frame_done),
    .slot_last   (WR_LAST),
    .slot        (wr_slot),
    .base        (wr_base),
    .line        (wr_line),
    .line_at_end (wr_line_end)
  );

  zbt_ring_pointer #(
    .LINES_PER_FRAME (LINES_PER_FRAME),
    .ADDR_W          (ADDR_W)
  ) u_rd_ptr (
    .clk         (clk),
    .reset       (reset),
    .line_clr    (frame_start),
    .line_inc    (rd_grant),
    .slot_adv    (rd_advance),
    .slot_last   (rd_last),
    .slot        (rd_slot),
    .base        (rd_base),
    .line        (rd_line),
    .line_at_end ()
  );

  // Writer FSM next state: a capture runs from capture_start to the grant
  // of the last word in the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WR_IDLE:    if (capture_start) state_d = WR_CAPTURE;
      WR_CAPTURE: if (wr_frame_done) state_d = WR_IDLE;
      default:    state_d = WR_IDLE;
    endcase
  end

  // Bookkeeping, ZBT command and read-return pipeline.
  always_comb begin
    frames_stored_d   = frames_stored_q;
    advance_pending_d = advance_pending_q;
    starve_d          = starve_q;
    zbt_we_d          = 1'b0;
    zbt_addr_d        = zbt_addr_q;
    zbt_wdata_d       = zbt_wdata_q;
    valid_pipe_d      = {valid_pipe_q[1:0], rd_grant};
    empty_pipe_d      = {empty_pipe_q[1:0], rd_empty};

    if (wr_frame_done && (frames_stored_q < FRAMES_MAX)) begin
      frames_stored_d = frames_stored_q + 1'b1;
    end

    // Extra one_hz pulses while pending are absorbed.
    if (rd_advance) begin
      advance_pending_d = 1'b0;
    end else if (one_hz_enable) begin
      advance_pending_d = 1'b1;
    end

    if (wr_grant) begin
      starve_d = '0;
    end else if (wr_contend && bus.rd_req) begin
      starve_d = starve_q + 1'b1;
    end

    // An empty-ring read still gets a grant but leaves the ZBT untouched.
    if (wr_grant) begin
      zbt_we_d    = 1'b1;
      zbt_addr_d  = wr_base + wr_line;
      zbt_wdata_d = bus.wr_data;
    end else if (rd_grant && !rd_empty) begin
      zbt_addr_d  = rd_base + rd_line;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= WR_IDLE;
      frames_stored_q   <= '0;
      advance_pending_q <= 1'b0;
      starve_q          <= '0;
      zbt_we_q          <= 1'b0;
      zbt_addr_q        <= '0;
      zbt_wdata_q       <= '0;
      valid_pipe_q      <= '0;
      empty_pipe_q      <= '0;
    end else begin
      state_q           <= state_d;
      frames_stored_q   <= frames_stored_d;
      advance_pending_q <= advance_pending_d;
      starve_q          <= starve_d;
      zbt_we_q          <= zbt_we_d;
      zbt_addr_q        <= zbt_addr_d;
      zbt_wdata_q       <= zbt_wdata_d;
      valid_pipe_q      <= valid_pipe_d;
      empty_pipe_q      <= empty_pipe_d;
    end
  end

  assign bus.wr_grant  = wr_grant;
  assign bus.rd_grant  = rd_grant;
  assign bus.rd_valid  = valid_pipe_q[2];
  assign bus.rd_data   = (valid_pipe_q[2] && !empty_pipe_q[2]) ? zbt_rdata : '0;
  assign frames_stored = frames_stored_q;
  assign zbt_we        = zbt_we_q;
  assign zbt_addr      = zbt_addr_q;
  assign zbt_wdata     = zbt_wdata_q;

endmodule
`default_nettype wire
